// File: rtl/pmix_pkg.sv
// Shared types for the phase-mixer code path: controller state encoding and the mixer code type.
package pmix_pkg;

    localparam int PMIX_CODE_W = 8;

    typedef logic [PMIX_CODE_W-1:0] pmix_code_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        SETTLE = 2'd2
    } pmix_state_t;

endpackage

// File: rtl/pmix_vote_acc.sv
// Signed saturating early/late vote accumulator; flags a step when the next value crosses +/-VOTE_TH.
module pmix_vote_acc #(
    parameter int VOTE_TH = 8
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_up,
    input  logic i_dn,
    output logic o_step_up,
    output logic o_step_dn
);
    localparam int AW = $clog2(VOTE_TH) + 2;
    localparam int WW = AW + 1;

    localparam logic signed [WW-1:0] TH_POS  = WW'(VOTE_TH);
    localparam logic signed [WW-1:0] TH_NEG  = -TH_POS;
    localparam logic signed [WW-1:0] ACC_MAX = WW'((1 << (AW - 1)) - 1);
    localparam logic signed [WW-1:0] ACC_MIN = ~ACC_MAX;

    logic signed [AW-1:0] r_acc;
    logic signed [WW-1:0] w_delta;
    logic signed [WW-1:0] w_sum;
    logic signed [WW-1:0] w_sat;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_delta = '0;
        if (i_up && !i_dn) begin
            w_delta = WW'(1);
        end else if (i_dn && !i_up) begin
            w_delta = '1;
        end
        w_sum = $signed({r_acc[AW-1], r_acc}) + w_delta;
        w_sat = w_sum;
        if (w_sum > ACC_MAX) begin
            w_sat = ACC_MAX;
        end else if (w_sum < ACC_MIN) begin
            w_sat = ACC_MIN;
        end
    end

    assign o_step_up = i_en && (w_sat >= TH_POS);
    assign o_step_dn = i_en && (w_sat <= TH_NEG);

    // Held at zero whenever not tracking, and restarted after every step or load.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (!i_en || i_clr || o_step_up || o_step_dn) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sat[AW-1:0];
        end
    end

endmodule

// File: rtl/pmix_code_ctrl.sv
// Phase-code controller: vote-filtered stepping of the mixer code with settle window, code load and lock.
// Build option: define PMIX_CTRL_WRAP_EN for modulo-256 code wrap; by default the code saturates at 0/255.
module pmix_code_ctrl
    import pmix_pkg::*;
#(
    parameter int VOTE_TH    = 8,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_CNT   = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   up,
    input  logic                   dn,
    input  logic                   ld_valid,
    input  logic [PMIX_CODE_W-1:0] ld_code,
    output logic                   ld_ready,
    output logic [PMIX_CODE_W-1:0] code,
    output logic                   code_upd,
    output logic                   lock
);
    localparam pmix_code_t STEP_C    = PMIX_CODE_W'(STEP);
    localparam pmix_code_t CODE_MAX  = '1;
    localparam logic [3:0] LOCK_C    = 4'(LOCK_CNT);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

    pmix_state_t r_state;
    logic [7:0]  r_settle;
    pmix_code_t  r_code;
    logic        r_code_upd;
    logic        r_lock;
    logic        r_last_dir;
    logic [3:0]  r_alt_cnt;

    logic        w_ld_acc;
    logic        w_track_en;
    logic        w_step_up;
    logic        w_step_dn;
    logic        w_step_any;
    logic        w_blocked;
    logic        w_step_go;
    pmix_code_t  w_step_code;
    logic [3:0]  w_alt_nxt;

    assign w_ld_acc   = ld_valid && (r_state != SETTLE);
    assign w_track_en = en && (r_state == TRACK);

    pmix_vote_acc #(
        .VOTE_TH (VOTE_TH)
    ) u_vote_acc (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .i_en      (w_track_en),
        .i_clr     (w_ld_acc),
        .i_up      (up),
        .i_dn      (dn),
        .o_step_up (w_step_up),
        .o_step_dn (w_step_dn)
    );

    assign w_step_any = w_step_up || w_step_dn;

    always_comb begin
        w_blocked   = 1'b0;
        w_step_code = r_code;
`ifdef PMIX_CTRL_WRAP_EN
        w_step_code = w_step_up ? (r_code + STEP_C) : (r_code - STEP_C);
`else
        // A step pinned at a rail is dropped but still consumes a settle window.
        if (w_step_up) begin
            w_blocked   = (r_code == CODE_MAX);
            w_step_code = (r_code > CODE_MAX - STEP_C) ? CODE_MAX : (r_code + STEP_C);
        end else begin
            w_blocked   = (r_code == '0);
            w_step_code = (r_code < STEP_C) ? '0 : (r_code - STEP_C);
        end
`endif
    end

    assign w_step_go = w_step_any && !w_ld_acc && !w_blocked;
    assign w_alt_nxt = (w_step_up != r_last_dir)
                     ? ((r_alt_cnt == LOCK_C) ? LOCK_C : (r_alt_cnt + 4'd1))
                     : 4'd0;

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_settle   <= '0;
            r_code     <= '0;
            r_code_upd <= 1'b0;
            r_lock     <= 1'b0;
            r_last_dir <= 1'b0;
            r_alt_cnt  <= '0;
        end else begin
            r_code_upd <= 1'b0;
            if (w_ld_acc) begin
                r_code     <= ld_code;
                r_code_upd <= 1'b1;
                r_alt_cnt  <= '0;
                r_lock     <= 1'b0;
            end else if (w_step_go) begin
                r_code     <= w_step_code;
                r_code_upd <= 1'b1;
                r_last_dir <= w_step_up;
                r_alt_cnt  <= w_alt_nxt;
                r_lock     <= (w_alt_nxt == LOCK_C);
            end

            if (!en) begin
                r_state  <= IDLE;
                r_settle <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!w_ld_acc) r_state <= TRACK;
                    end
                    TRACK: begin
                        if (w_ld_acc || w_step_any) begin
                            r_state  <= SETTLE;
                            r_settle <= SETTLE_LD;
                        end
                    end
                    SETTLE: begin
                        if (r_settle == '0) r_state  <= TRACK;
                        else                r_settle <= r_settle - 8'd1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ld_ready = (r_state != SETTLE);
    assign code     = r_code;
    assign code_upd = r_code_upd;
    assign lock     = r_lock;

endmodule

// File: tb/tb_pmix_code_ctrl.sv
// Self-checking bench for pmix_code_ctrl: directed scenarios plus biased random votes against a cycle model.
module tb_pmix_code_ctrl;

    localparam int VOTE_TH    = 8;
    localparam int STEP       = 1;
    localparam int SETTLE_CYC = 4;
    localparam int LOCK_CNT   = 4;

`ifdef PMIX_CTRL_WRAP_EN
    localparam int WRAP_HI = 0;
    localparam int WRAP_LO = 255;
    localparam int EDGE_UPD = 1;
`else
    localparam int WRAP_HI = 255;
    localparam int WRAP_LO = 0;
    localparam int EDGE_UPD = 0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_TRACK  = 1;
    localparam int M_SETTLE = 2;

    logic       clk_in   = 1'b0;
    logic       rst_n    = 1'b1;
    logic       en       = 1'b0;
    logic       up       = 1'b0;
    logic       dn       = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_code  = 8'd0;
    logic       ld_ready;
    logic [7:0] code;
    logic       code_upd;
    logic       lock;

    always #5 clk_in = ~clk_in;

    pmix_code_ctrl #(
        .VOTE_TH    (VOTE_TH),
        .STEP       (STEP),
        .SETTLE_CYC (SETTLE_CYC),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .dn       (dn),
        .ld_valid (ld_valid),
        .ld_code  (ld_code),
        .ld_ready (ld_ready),
        .code     (code),
        .code_upd (code_upd),
        .lock     (lock)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, kept as plain integers.
    int m_mode, m_acc, m_left, m_code, m_alt;
    bit m_upd, m_lock, m_last_up;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_acc = 0; m_left = 0; m_code = 0; m_alt = 0;
        m_upd = 0; m_lock = 0; m_last_up = 0;
    endtask

    task automatic model_step(input bit e, input bit u, input bit d, input bit lv, input int lc);
        bit acc_ld;
        int s, dir, nc;
        acc_ld = lv && (m_mode != M_SETTLE);
        m_upd  = 0;
        dir    = 0;
        s = m_acc + ((u && !d) ? 1 : 0) - ((d && !u) ? 1 : 0);
        if (acc_ld) begin
            m_code = lc; m_upd = 1; m_alt = 0; m_lock = 0;
        end
        if (!e) begin
            m_mode = M_IDLE; m_acc = 0; m_left = 0;
        end else if (m_mode == M_IDLE) begin
            m_acc = 0;
            if (!acc_ld) m_mode = M_TRACK;
        end else if (m_mode == M_TRACK) begin
            if (acc_ld) begin
                m_acc = 0; m_mode = M_SETTLE; m_left = SETTLE_CYC;
            end else if (s >= VOTE_TH || s <= -VOTE_TH) begin
                dir = (s > 0) ? 1 : -1;
                m_acc = 0; m_mode = M_SETTLE; m_left = SETTLE_CYC;
            end else begin
                m_acc = s;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_mode = M_TRACK;
        end
        if (dir != 0) begin
            nc = m_code + dir * STEP;
`ifdef PMIX_CTRL_WRAP_EN
            nc = (nc + 256) % 256;
`else
            if (nc > 255) nc = 255;
            if (nc < 0)   nc = 0;
`endif
            if (nc != m_code) begin
                m_code = nc;
                m_upd  = 1;
                if ((dir > 0) != m_last_up) m_alt = (m_alt + 1 > LOCK_CNT) ? LOCK_CNT : m_alt + 1;
                else                        m_alt = 0;
                m_last_up = (dir > 0);
                m_lock = (m_alt == LOCK_CNT);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".code"}, code, m_code);
        check({tag, ".code_upd"}, code_upd, m_upd);
        check({tag, ".lock"}, lock, m_lock);
        check({tag, ".ld_ready"}, ld_ready, m_mode != M_SETTLE);
    endtask

    // Called at a falling edge: drive inputs, advance the model over the next rising edge, check.
    task automatic cycle(input bit e, input bit u, input bit d, input bit lv, input logic [7:0] lc, input string tag);
        en = e; up = u; dn = d; ld_valid = lv; ld_code = lc;
        model_step(e, u, d, lv, int'(lc));
        @(negedge clk_in);
        compare_all(tag);
    endtask

    task automatic votes(input bit u, input bit d, input string tag);
        repeat (VOTE_TH) cycle(1'b1, u, d, 1'b0, 8'd0, tag);
    endtask

    task automatic settle();
        repeat (SETTLE_CYC) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "settle");
    endtask

    initial begin
        int  bias_left;
        bit  bias_up;
        bit  e, u, d, lv;
        int  r;
        logic [7:0] lc;

        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst.code", code, 0);
        check("rst.lock", lock, 0);
        check("rst.ld_ready", ld_ready, 1);
        check("rst.code_upd", code_upd, 0);
        @(negedge clk_in);
        rst_n = 1'b1;

        repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "idle");
        check("idle.code_held", code, 0);

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "enter_track");
        repeat (VOTE_TH - 1) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "up_acc");
        check("up_acc.no_step", code, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "up_cross");
        check("step_up.code", code, 1);
        check("step_up.pulse", code_upd, 1);
        for (int k = 0; k < SETTLE_CYC; k++) begin
            check("settle.ready_low", ld_ready, 0);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "settle_win");
        end
        check("settle.ready_back", ld_ready, 1);

        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd255, "load_ff");
        check("load_ff.code", code, 255);
        settle();
        votes(1'b1, 1'b0, "hi_edge");
        check("hi_edge.code", code, WRAP_HI);
        check("hi_edge.pulse", code_upd, EDGE_UPD);
        check("hi_edge.ready", ld_ready, 0);
        settle();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, "load_00");
        check("load_00.pulse", code_upd, 1);
        settle();
        votes(1'b0, 1'b1, "lo_edge");
        check("lo_edge.code", code, WRAP_LO);
        check("lo_edge.pulse", code_upd, EDGE_UPD);
        settle();

        repeat (50) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "cancel");
        check("cancel.code", code, WRAP_LO);

        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h80, "load_80");
        settle();
        votes(1'b1, 1'b0, "pre_up1"); settle();
        votes(1'b1, 1'b0, "pre_up2"); settle();
        votes(1'b0, 1'b1, "alt1");    settle();
        votes(1'b1, 1'b0, "alt2");    settle();
        votes(1'b0, 1'b1, "alt3");
        check("alt3.lock", lock, 0);
        settle();
        votes(1'b1, 1'b0, "alt4");
        check("alt4.lock", lock, 1);
        check("alt4.code", code, 8'h82);
        settle();

        repeat (VOTE_TH - 1) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "coll_acc");
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h40, "collide");
        check("collide.code", code, 8'h40);
        check("collide.lock", lock, 0);
        check("collide.pulse", code_upd, 1);
        settle();
        repeat (VOTE_TH - 1) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "coll_clr");
        check("collide.acc_cleared", code, 8'h40);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "coll_next");
        check("collide.next_step", code, 8'h41);
        settle();

        votes(1'b1, 1'b0, "abort_step");
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "abort_settle");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "abort_en");
        check("abort.ready", ld_ready, 1);
        check("abort.code", code, 8'h42);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "reenter");

        votes(1'b1, 1'b0, "rst_step");
        check("rst_step.code", code, 8'h43);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "rst_settle");
        en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.code", code, 0);
        check("arst.ready", ld_ready, 1);
        check("arst.lock", lock, 0);
        check("arst.pulse", code_upd, 0);
        @(negedge clk_in);
        rst_n = 1'b1;

        bias_left = 0;
        bias_up   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 compare_all("rnd_arst");
                @(negedge clk_in);
                rst_n = 1'b1;
            end
            if (bias_left == 0) begin
                bias_up   = ~bias_up;
                bias_left = $urandom_range(10, 60);
            end
            bias_left--;
            r = $urandom_range(0, 9);
            u = 1'b0;
            d = 1'b0;
            if (r < 6) begin
                u = bias_up; d = !bias_up;
            end else if (r < 8) begin
                u = !bias_up; d = bias_up;
            end else if (r == 8) begin
                u = 1'b1; d = 1'b1;
            end
            e  = ($urandom_range(0, 49) != 0);
            lv = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       lc = 8'd0;
                1:       lc = 8'd255;
                default: lc = 8'($urandom_range(0, 255));
            endcase
            cycle(e, u, d, lv, lc, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pmix_code_ctrl.md
# pmix_code_ctrl

Phase-code controller directly upstream of the phase mixer. Filters early/late votes from the phase detector in an up/down accumulator and steps the 8-bit mixer `code` once the accumulated vote crosses a threshold. After each step it holds for a settle window. It also accepts externally loaded codes through a valid/ready handshake and flags lock when the loop dithers around a stable phase.

## Interface
Parameters:
- VOTE_TH, 8: net vote magnitude that triggers a code step (1..127).
- STEP, 1: code increment/decrement per step (1..16).
- SETTLE_CYC, 4: cycles votes are ignored after any code change (1..255).
- LOCK_CNT, 4: consecutive direction-alternating steps required for lock (2..15).

Ports:
- clk_in  in  1  block clock; same clock that drives the mixer's reference input domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  tracking enable.
- up  in  1  phase-detector "late" vote (advance code).
- dn  in  1  phase-detector "early" vote (retard code).
- ld_valid  in  1  external code load request.
- ld_code  in  8  code to load.
- ld_ready  out  1  load accepted when ld_valid & ld_ready.
- code  out  8  registered mixer phase code.
- code_upd  out  1  one-cycle pulse, cycle in which `code` changed.
- lock  out  1  loop locked.

Reset is rst_n, asynchronous, active-low; the clock is clk_in.

## Operation
- Reset values: code=0, code_upd=0, lock=0, accumulator=0, settle counter=0, state=IDLE, ld_ready=1.
- States:
  - IDLE: en=0; accumulator held at 0; code held. en=1 moves to TRACK next cycle.
  - TRACK: accumulator += (up & ~dn) − (dn & ~up). up=dn=1 or up=dn=0 adds 0. Accumulator is signed, width $clog2(VOTE_TH)+2.
    - If the next value ≥ +VOTE_TH: code += STEP, accumulator cleared, go to SETTLE.
    - If the next value ≤ −VOTE_TH: code −= STEP, accumulator cleared, go to SETTLE.
  - SETTLE: votes ignored; counter loads SETTLE_CYC−1 on entry and decrements to 0, then returns to TRACK. Total time in SETTLE is exactly SETTLE_CYC cycles.
- en=0 in any state forces IDLE next cycle and clears the accumulator and settle counter. code and lock are held.
- ld_ready = (state != SETTLE).
  - Accepted load in TRACK: code = ld_code, accumulator cleared, go to SETTLE. Load has priority over a same-cycle vote step.
  - Accepted load in IDLE: code = ld_code, state stays IDLE.
  - Every accepted load clears lock and the lock counter.
- code_upd pulses on every cycle in which code changes, whether from a step or a load. A load equal to the current code still pulses.
- Lock:
  - A 1-bit last-direction register tracks step direction.
  - A step opposite to the last direction increments the alternation counter, saturating at LOCK_CNT.
  - A step in the same direction resets the counter to 0.
  - lock=1 while the counter equals LOCK_CNT.
- Arithmetic: code math is 8-bit; boundary behaviour is set by the Configuration section below.

## Timing
- A vote sampled in cycle N that crosses the threshold produces the new code and code_upd in cycle N+1 (1-cycle latency).
- A load handshake in cycle N produces code=ld_code in cycle N+1; ld_ready is low from N+1 for SETTLE_CYC cycles.
- The earliest possible second step comes SETTLE_CYC+VOTE_TH cycles after the first.
- Reset asserted mid-SETTLE or mid-load aborts immediately to the reset values; no partial update.
- code only changes on clk_in edges, so it is glitch-free for the downstream mixer, which samples it on its own clock.

## Configuration
- PMIX_CTRL_WRAP_EN defined: code wraps modulo 256 (255+1 → 0, 0−1 → 255), for continuous-rotation phase tracking.
- PMIX_CTRL_WRAP_EN undefined: code saturates at 0 and 255.
  - A step at the bound leaves code unchanged, asserts no code_upd, still clears the accumulator and still enters SETTLE.
  - A blocked step does not update the lock direction state.

## Structure
- Package pmix_pkg holds:
  - the state enum typedef (IDLE, TRACK, SETTLE);
  - the code width constant PMIX_CODE_W=8 and code typedef, shared with the mixer and its UVM environment.
- One sub-module, pmix_vote_acc: the signed saturating vote accumulator with threshold compare. It outputs step_up/step_dn pulses and takes a clear input.

## Test plan
- Reset/idle: rst_n=0 → code=0, lock=0, ld_ready=1; release with en=0 and 20 up votes → code stays 0.
- Step up (VOTE_TH=8, STEP=1): en=1, up held 8 cycles → code=1 with one code_upd pulse one cycle after the 8th vote; ld_ready low for 4 cycles.
- Wrap/saturate: load 255, then 8 up votes → code=0 with PMIX_CTRL_WRAP_EN; code=255 and no code_upd without it.
- Load vs step collision: the 8th up vote and ld_valid with ld_code=0x40 in the same TRACK cycle → code=0x40, accumulator 0, lock cleared.
- Vote cancel: up=dn=1 for 50 cycles → no step. Alternating up and dn blocks of 8 votes → lock rises after the 4th alternating step.
- Mid-settle abort: en dropped 2 cycles into SETTLE → IDLE next cycle, code held. rst_n pulsed in SETTLE → all outputs return to reset values asynchronously.
